sm_warp_ibuffer: RTL
====================

# sm_warp_ibuffer

Per-warp instruction buffer between the decode stage and the warp scheduler/issue stage of the SM core. It is a parametrised successor to the fixed two-entry per-warp buffer, with these differences:
- The warp count, depth and payload width are parameters.
- It adds first-word-fall-through read-out with a correct per-warp head multiplexer.
- It adds per-warp flush for branch redirect, per-warp occupancy counts and sticky error flags.
- An optional same-cycle decode-to-issue bypass is available.

## Interface
- `NUM_WARP`, default 8: number of warps and independent FIFOs (≥2).
- `DEPTH`, default 4: entries per warp FIFO. Must be a power of two, ≥2.
- `DATA_WIDTH`, default 136: packed decode payload width, opaque to this block.
- `WID_W`, default `$clog2(NUM_WARP)`: warp-id width.
- `CNT_W`, default `$clog2(DEPTH)+1`: occupancy counter width.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid_i`  in  1  decoded instruction valid.
- `wr_wid_i`  in  WID_W  target warp of the write.
- `wr_data_i`  in  DATA_WIDTH  packed decode fields.
- `issue_oh_i`  in  NUM_WARP  one-hot issue select; all-zero means no issue.
- `flush_i`  in  1  flush request.
- `flush_wid_i`  in  WID_W  warp to flush.
- `out_valid_o`  out  1  issued instruction valid.
- `out_wid_o`  out  WID_W  warp id of the issued instruction.
- `out_data_o`  out  DATA_WIDTH  issued payload.
- `has_data_o`  out  NUM_WARP  per-warp non-empty.
- `avail_o`  out  NUM_WARP  per-warp not full.
- `count_o`  out  NUM_WARP*CNT_W  per-warp occupancy; warp w occupies bits [w*CNT_W +: CNT_W].
- `ovf_err_o`  out  1  sticky: a write was dropped because the target was full.
- `udf_err_o`  out  1  sticky: an issue targeted an empty warp, or `issue_oh_i` was not one-hot.

## Operation
- Each warp has one circular FIFO with a read pointer, a write pointer and a count. Pointers are log2(DEPTH) bits and wrap naturally.
- **Write.** Accepted when `wr_valid_i`=1, count[wr_wid]<DEPTH, and warp wr_wid is not being flushed this cycle.
  - If the target is full, the write is dropped and `ovf_err_o` is set.
  - A write to a full warp that is also being issued the same cycle is still dropped. `avail_o` is the only credit the decoder may use.
- **Issue (read).** The warp w selected by `issue_oh_i` is popped if count[w]>0.
  - Outputs are combinational, first-word-fall-through: `out_data_o` is the head of w, `out_wid_o`=w, `out_valid_o`=1.
  - Issue to an empty warp: `out_valid_o`=0, no state change, `udf_err_o` set.
  - `issue_oh_i` with more than one bit set: treated as no issue, `out_valid_o`=0, `udf_err_o` set.
- **Simultaneous push and pop on the same non-full warp.** Both occur; the count is unchanged.
- **Flush.** On the cycle after `flush_i`, warp flush_wid has pointers and count = 0.
  - The flush has priority over any write and any issue to that warp in the same cycle. Issue to the flushed warp gives `out_valid_o`=0 and does not set `udf_err_o`.
  - Other warps are unaffected.
- **Count arithmetic.** count = count + push − pop, range 0..DEPTH, never wraps.
- **Status outputs.**
  - `has_data_o`[w] = (count[w]≠0).
  - `avail_o`[w] = (count[w]≠DEPTH).
  - Both reflect registered state only; no same-cycle look-ahead.
- **Error flags.** Clear only on reset.
- **Storage.** Payload storage is not reset; only pointers, counts and flags are.

## Timing
- Write-to-visible latency is 1 cycle: data written in cycle N is issuable in cycle N+1 (without bypass).
- Issue read latency is 0 cycles (combinational from `issue_oh_i`). The pop takes effect at the next clock edge.
- Values during and after reset:
  - All counts = 0, `has_data_o`=0, `avail_o`=all ones, `out_valid_o`=0.
  - `out_wid_o`=0 and `out_data_o`=0 whenever `out_valid_o`=0 (payload gated).
  - `ovf_err_o`=0, `udf_err_o`=0.
- Asserting `rst` mid-operation empties every warp immediately, asynchronously. In-flight writes are lost.

## Configuration
- `SM_IBUF_BYPASS_EN` defined:
  - Condition: a write to warp w, an issue to w and count[w]=0 in the same cycle, with no flush of w.
  - Response: the write bypasses storage. `out_data_o`=`wr_data_i`, `out_wid_o`=w, `out_valid_o`=1. Nothing is stored, the count stays 0, and `udf_err_o` is not set.
  - This gives a 0-cycle decode-to-issue path.
- `SM_IBUF_BYPASS_EN` undefined:
  - The same case stores the write (count becomes 1).
  - The issue sees empty: `out_valid_o`=0 and `udf_err_o` is set.

## Test plan
- **Reset then fill.** Stimulus: reset, then write DEPTH=4 entries (0xA0..0xA3) to warp 3, then a fifth write. Required: count 1..4; `avail_o`[3] drops after the 4th; the 5th is dropped; `ovf_err_o`=1; other warps unchanged.
- **FWFT order.** Stimulus: from the full warp 3, issue 4 consecutive cycles. Required: `out_data_o` is 0xA0, 0xA1, 0xA2, 0xA3 in order with `out_wid_o`=3; `has_data_o`[3]=0 afterwards. Then a 5th issue gives `out_valid_o`=0 and `udf_err_o`=1.
- **Wrap-around.** Stimulus: 10 interleaved push/pop pairs on warp 0 at count 2. Required: FIFO order preserved across pointer wrap; count stays 2.
- **Flush priority.** Stimulus: warp 5 holds 3 entries; one cycle with flush of 5, write to 5 and issue of 5. Required: `out_valid_o`=0; count[5]=0 next cycle; write dropped; no error flags.
- **Bypass.** Stimulus: empty warp 2, same-cycle write of 0x55 and issue of warp 2. Required with `SM_IBUF_BYPASS_EN`: `out_valid_o`=1, data 0x55, count stays 0. Required without: `out_valid_o`=0, `udf_err_o`=1, count[2]=1.
- **Async reset mid-operation.** Stimulus: multiple warps partly full, assert `rst` between clock edges. Required: all counts 0, `avail_o` all ones, flags 0, immediately without waiting for a clock.

Source files
------------

// File: rtl/sm_warp_ibuffer.sv
// Per-warp FWFT instruction buffer between decode and issue; issue read is combinational, pop/push land next edge.
// Writes to a full or flushing warp are dropped (avail_o is the decoder's credit); SM_IBUF_BYPASS_EN enables same-cycle decode-to-issue bypass.
module sm_warp_ibuffer #(
    parameter int NUM_WARP   = 8,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 136,
    parameter int WID_W      = $clog2(NUM_WARP),
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid_i,
    input  logic [WID_W-1:0]          wr_wid_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic [NUM_WARP-1:0]       issue_oh_i,
    input  logic                      flush_i,
    input  logic [WID_W-1:0]          flush_wid_i,
    output logic                      out_valid_o,
    output logic [WID_W-1:0]          out_wid_o,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic [NUM_WARP-1:0]       has_data_o,
    output logic [NUM_WARP-1:0]       avail_o,
    output logic [NUM_WARP*CNT_W-1:0] count_o,
    output logic                      ovf_err_o,
    output logic                      udf_err_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem    [NUM_WARP][DEPTH];
    logic [PTR_W-1:0]      rd_ptr [NUM_WARP];
    logic [PTR_W-1:0]      wr_ptr [NUM_WARP];
    logic [CNT_W-1:0]      cnt    [NUM_WARP];
    logic                  ovf_err, udf_err;

    logic [WID_W-1:0] issue_wid;
    logic issue_any, issue_one, issue_flushed, issue_empty;
    logic wr_flushed, wr_full, bypass, push, pop;

    always_comb begin
        issue_wid = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (issue_oh_i[w]) issue_wid = WID_W'(w);
        end
    end

    assign issue_any     = |issue_oh_i;
    assign issue_one     = issue_any && ((issue_oh_i & (issue_oh_i - NUM_WARP'(1))) == '0);
    assign issue_flushed = flush_i && (flush_wid_i == issue_wid);
    assign issue_empty   = (cnt[issue_wid] == '0);
    assign wr_flushed    = flush_i && (flush_wid_i == wr_wid_i);
    assign wr_full       = (cnt[wr_wid_i] == CNT_W'(DEPTH));

`ifdef SM_IBUF_BYPASS_EN
    assign bypass = wr_valid_i && issue_one && !issue_flushed && issue_empty && (wr_wid_i == issue_wid);
`else
    assign bypass = 1'b0;
`endif

    assign pop  = issue_one && !issue_flushed && !issue_empty;
    assign push = wr_valid_i && !wr_flushed && !wr_full && !bypass;

    // Payload is gated to zero whenever nothing is issued.
    always_comb begin
        out_valid_o = pop || bypass;
        out_wid_o   = '0;
        out_data_o  = '0;
        if (bypass) begin
            out_wid_o  = issue_wid;
            out_data_o = wr_data_i;
        end else if (pop) begin
            out_wid_o  = issue_wid;
            out_data_o = mem[issue_wid][rd_ptr[issue_wid]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_wid_i][wr_ptr[wr_wid_i]] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARP; w++) begin
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
                cnt[w]    <= '0;
            end
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARP; w++) begin
                if (flush_i && (flush_wid_i == WID_W'(w))) begin
                    rd_ptr[w] <= '0;
                    wr_ptr[w] <= '0;
                    cnt[w]    <= '0;
                end else begin
                    if (push && (wr_wid_i == WID_W'(w))) wr_ptr[w] <= wr_ptr[w] + PTR_W'(1);
                    if (pop && (issue_wid == WID_W'(w))) rd_ptr[w] <= rd_ptr[w] + PTR_W'(1);
                    cnt[w] <= cnt[w] + CNT_W'(push && (wr_wid_i == WID_W'(w)))
                                     - CNT_W'(pop && (issue_wid == WID_W'(w)));
                end
            end
            if (wr_valid_i && !wr_flushed && !bypass && wr_full) ovf_err <= 1'b1;
            // Issue to a flushed warp is a legal no-op, not an underflow.
            if (issue_any && (!issue_one || (!issue_flushed && !pop && !bypass))) udf_err <= 1'b1;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARP; w++) begin
            has_data_o[w]               = (cnt[w] != '0);
            avail_o[w]                  = (cnt[w] != CNT_W'(DEPTH));
            count_o[w*CNT_W +: CNT_W]   = cnt[w];
        end
    end

    assign ovf_err_o = ovf_err;
    assign udf_err_o = udf_err;
endmodule
